// File: rtl/palette_ram.sv
`default_nettype none
// ============================================================================
// Module   : palette_ram
// Brief    : Runtime-writable colour palette with a two-stage pixel pipeline
//            and a frame-synchronised brightness fade engine. Converts a
//            per-pixel colour index into scaled VGA RGB channels.
// Revision : 1.0 - initial release
// ============================================================================
module palette_ram #(
  parameter int IDX_W    = 4,
  parameter int CH_W     = 8,
  parameter int LVL_W    = 4,
  parameter int FADE_DIV = 2
) (
  input  logic                Clk,
  input  logic                Reset,
  input  logic [IDX_W-1:0]    colorIdx,
  input  logic                blank_n,
  input  logic                frame_start,
  input  logic                wr_en,
  input  logic [IDX_W-1:0]    wr_idx,
  input  logic [3*CH_W-1:0]   wr_color,
  input  logic [1:0]          fade_cmd,
  output logic [CH_W-1:0]     VGA_R,
  output logic [CH_W-1:0]     VGA_G,
  output logic [CH_W-1:0]     VGA_B,
  output logic                blank_n_out,
  output logic                fade_busy,
  output logic                fade_done,
  output logic [LVL_W:0]      fade_level
);

  localparam int N_ENT  = 1 << IDX_W;
  localparam int PW     = 3 * CH_W;
  localparam int PROD_W = CH_W + LVL_W + 1;
  localparam int DIV_W  = (FADE_DIV < 2) ? 1 : $clog2(FADE_DIV + 1);
  // Widening/narrowing of the 8-bit default channel values (MSB aligned)
  localparam int CH_EXT = (CH_W > 8) ? CH_W : 8;
  localparam int PAD    = (CH_W > 8) ? CH_W - 8 : 0;
  localparam int TRUNC  = (CH_W < 8) ? 8 - CH_W : 0;

  localparam logic [LVL_W:0] LVL_FULL = {1'b1, {LVL_W{1'b0}}};
  localparam logic [LVL_W:0] LVL_ZERO = '0;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(FADE_DIV);

  localparam logic [1:0] CMD_OUT  = 2'b01;
  localparam logic [1:0] CMD_IN   = 2'b10;
  localparam logic [1:0] CMD_SNAP = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_OUT  = 2'd1,
    ST_IN   = 2'd2
  } fade_state_t;

  // --------------------------------------------------------------------------
  // Default palette contents, expressed as 8-bit-per-channel colours
  // --------------------------------------------------------------------------
  function automatic logic [23:0] default_rgb8(input int idx);
    logic [23:0] c;
    case (idx)
      0:       c = 24'h282246;
      1:       c = 24'h213822;
      2:       c = 24'h3E6B41;
      3:       c = 24'h80BB84;
      4:       c = 24'hD624C1;
      5:       c = 24'h252525;
      6:       c = 24'h000000;
      7:       c = 24'h9A9A9A;
      8:       c = 24'hFF9F33;
      9:       c = 24'hFFFFFF;
      10:      c = 24'h525468;
      11:      c = 24'h8780A8;
      default: c = 24'h282246;
    endcase
    return c;
  endfunction

  // Fit an 8-bit channel into CH_W bits keeping the MSBs aligned
  function automatic logic [CH_W-1:0] fit_ch(input logic [7:0] c8);
    logic [CH_EXT-1:0] t;
    t = CH_EXT'(c8);
    t = t << PAD;
    t = t >> TRUNC;
    return CH_W'(t);
  endfunction

  function automatic logic [PW-1:0] default_entry(input int idx);
    logic [23:0] c;
    c = default_rgb8(idx);
    return {fit_ch(c[23:16]), fit_ch(c[15:8]), fit_ch(c[7:0])};
  endfunction

  // Brightness scaling: (ch * level) >> LVL_W, truncating
  function automatic logic [CH_W-1:0] scale_ch(input logic [CH_W-1:0] ch,
                                               input logic [LVL_W:0]  lvl);
    logic [PROD_W-1:0] p;
    p = PROD_W'(ch) * PROD_W'(lvl);
    return CH_W'(p >> LVL_W);
  endfunction

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [PW-1:0]     pal_q [N_ENT];
  logic [PW-1:0]     pal_d [N_ENT];

  logic [PW-1:0]     pix1_q, pix1_d;
  logic              blank1_q, blank1_d;
  logic [LVL_W:0]    lvl1_q, lvl1_d;

  logic [CH_W-1:0]   r_out_q, r_out_d;
  logic [CH_W-1:0]   g_out_q, g_out_d;
  logic [CH_W-1:0]   b_out_q, b_out_d;
  logic              blank2_q, blank2_d;

  fade_state_t       state_q, state_d;
  logic [LVL_W:0]    level_q, level_d;
  logic [DIV_W-1:0]  div_q, div_d;
  logic              done_q, done_d;

  logic [DIV_W-1:0]  div_inc;
  logic              step_now;

  // Palette write port; stage-1 read below sees pal_q, i.e. old contents
  always_comb begin
    pal_d = pal_q;
    if (wr_en) begin
      pal_d[wr_idx] = wr_color;
    end
  end

  // Palette storage, reloaded with the default table on reset
  always_ff @(posedge Clk) begin
    if (Reset) begin
      for (int i = 0; i < N_ENT; i++) begin
        pal_q[i] <= default_entry(i);
      end
    end else begin
      pal_q <= pal_d;
    end
  end

  // Stage 1 lookup plus stage 2 scaling/blanking
  always_comb begin
    pix1_d   = pal_q[colorIdx];
    blank1_d = blank_n;
    lvl1_d   = level_q;
    blank2_d = blank1_q;
    r_out_d  = '0;
    g_out_d  = '0;
    b_out_d  = '0;
    if (blank1_q) begin
      r_out_d = scale_ch(pix1_q[PW-1 -: CH_W],     lvl1_q);
      g_out_d = scale_ch(pix1_q[2*CH_W-1 -: CH_W], lvl1_q);
      b_out_d = scale_ch(pix1_q[CH_W-1:0],         lvl1_q);
    end
  end

  // Pixel pipeline registers
  always_ff @(posedge Clk) begin
    if (Reset) begin
      pix1_q   <= '0;
      blank1_q <= 1'b0;
      lvl1_q   <= LVL_FULL;
      r_out_q  <= '0;
      g_out_q  <= '0;
      b_out_q  <= '0;
      blank2_q <= 1'b0;
    end else begin
      pix1_q   <= pix1_d;
      blank1_q <= blank1_d;
      lvl1_q   <= lvl1_d;
      r_out_q  <= r_out_d;
      g_out_q  <= g_out_d;
      b_out_q  <= b_out_d;
      blank2_q <= blank2_d;
    end
  end

  assign div_inc  = div_q + DIV_W'(1);
  assign step_now = frame_start && (div_inc == DIV_LAST);

  // Fade engine next-state: snap has priority, endpoints finish with a done pulse
  always_comb begin
    state_d = state_q;
    level_d = level_q;
    div_d   = div_q;
    done_d  = 1'b0;
    if (fade_cmd == CMD_SNAP) begin
      state_d = ST_IDLE;
      level_d = LVL_FULL;
      div_d   = '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (fade_cmd == CMD_OUT) begin
            state_d = ST_OUT;
            div_d   = '0;
          end else if (fade_cmd == CMD_IN) begin
            state_d = ST_IN;
            div_d   = '0;
          end
        end
        ST_OUT: begin
          if (level_q == LVL_ZERO) begin
            // Entered while already dark: finish without changing level
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end else if (frame_start) begin
            if (step_now) begin
              div_d   = '0;
              level_d = level_q - 1'b1;
              if (level_q == {{LVL_W{1'b0}}, 1'b1}) begin
                state_d = ST_IDLE;
                done_d  = 1'b1;
              end
            end else begin
              div_d = div_inc;
            end
          end
        end
        ST_IN: begin
          if (level_q == LVL_FULL) begin
            // Entered while already at full: finish without changing level
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end else if (frame_start) begin
            if (step_now) begin
              div_d   = '0;
              level_d = level_q + 1'b1;
              if (level_q == LVL_FULL - 1'b1) begin
                state_d = ST_IDLE;
                done_d  = 1'b1;
              end
            end else begin
              div_d = div_inc;
            end
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // Fade engine registers; reset aborts any fade at full brightness
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= ST_IDLE;
      level_q <= LVL_FULL;
      div_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      level_q <= level_d;
      div_q   <= div_d;
      done_q  <= done_d;
    end
  end

  assign VGA_R       = r_out_q;
  assign VGA_G       = g_out_q;
  assign VGA_B       = b_out_q;
  assign blank_n_out = blank2_q;
  assign fade_busy   = (state_q != ST_IDLE);
  assign fade_done   = done_q;
  assign fade_level  = level_q;

endmodule
`default_nettype wire
